// File: rtl/avalon_arbiter_pkg.sv
// Shared types and default widths for the two-port Avalon arbiter.
package avalon_arbiter_pkg;

   localparam int DEFAULT_INTERFACE_WIDTH_BITS = 128;
   localparam int DEFAULT_INTERFACE_ADDR_BITS  = 26;

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } arb_state_t;

   // A requester wants the bus whenever either strobe is raised.
   function automatic logic isRequesting(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/avalon_arbiter.sv
// Two-port Avalon-MM arbiter: m0 (display reader) has priority from IDLE,
// m1 (fractal writer) is protected from preemption until its beat limit.
module avalon_arbiter
   import avalon_arbiter_pkg::*;
#(
   parameter int INTERFACE_WIDTH_BITS = DEFAULT_INTERFACE_WIDTH_BITS,
   parameter int INTERFACE_ADDR_BITS  = DEFAULT_INTERFACE_ADDR_BITS,
   parameter int MAX_GRANT_BEATS      = 64
) (
   input  logic                              interface_clock,
   input  logic                              reset,

   input  logic [INTERFACE_ADDR_BITS-1:0]    m0_address,
   input  logic [INTERFACE_WIDTH_BITS/8-1:0] m0_byte_enable,
   input  logic                              m0_read,
   input  logic                              m0_write,
   input  logic [INTERFACE_WIDTH_BITS-1:0]   m0_write_data,
   output logic [INTERFACE_WIDTH_BITS-1:0]   m0_read_data,
   output logic                              m0_acknowledge,

   input  logic [INTERFACE_ADDR_BITS-1:0]    m1_address,
   input  logic [INTERFACE_WIDTH_BITS/8-1:0] m1_byte_enable,
   input  logic                              m1_read,
   input  logic                              m1_write,
   input  logic [INTERFACE_WIDTH_BITS-1:0]   m1_write_data,
   output logic [INTERFACE_WIDTH_BITS-1:0]   m1_read_data,
   output logic                              m1_acknowledge,

   output logic [INTERFACE_ADDR_BITS-1:0]    interface_address,
   output logic [INTERFACE_WIDTH_BITS/8-1:0] interface_byte_enable,
   output logic                              interface_read,
   output logic                              interface_write,
   output logic [INTERFACE_WIDTH_BITS-1:0]   interface_write_data,
   input  logic [INTERFACE_WIDTH_BITS-1:0]   interface_read_data,
   input  logic                              interface_acknowledge,

   output logic                              protocol_error,
   input  logic                              protocol_error_reset
);

   localparam int BEAT_BITS = $clog2(MAX_GRANT_BEATS + 1);
   localparam logic [BEAT_BITS-1:0] BEAT_MAX      = BEAT_BITS'(MAX_GRANT_BEATS);
   localparam logic [BEAT_BITS-1:0] BEAT_LAST_ACK = BEAT_BITS'(MAX_GRANT_BEATS - 1);

   arb_state_t             r_state;
   arb_state_t             w_nextState;
   logic [BEAT_BITS-1:0]   r_beatCount;
   logic                   r_protocolError;

   logic                   w_m0Req;
   logic                   w_m1Req;
   logic                   w_limitHit;
   logic                   w_errSet;

   assign w_m0Req    = isRequesting(m0_read, m0_write);
   assign w_m1Req    = isRequesting(m1_read, m1_write);
   assign w_limitHit = interface_acknowledge && (r_beatCount >= BEAT_LAST_ACK);

   // Read and write together is illegal; so is an acknowledge with no owner.
   assign w_errSet = (m0_read & m0_write) | (m1_read & m1_write)
                   | ((r_state == IDLE) & interface_acknowledge);

   assign m0_read_data   = interface_read_data;
   assign m1_read_data   = interface_read_data;
   assign protocol_error = r_protocolError;

   always_ff @(posedge interface_clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The grant only moves when the owner releases or on an acknowledged beat,
   // so a transfer already on the bus is never redirected to the other port.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_m0Req) begin
               w_nextState = GRANT0;
            end else if (w_m1Req) begin
               w_nextState = GRANT1;
            end
         end
         GRANT0: begin
            if (!w_m0Req) begin
               w_nextState = w_m1Req ? GRANT1 : IDLE;
            end else if (w_limitHit && w_m1Req) begin
               w_nextState = GRANT1;
            end
         end
         GRANT1: begin
            if (!w_m1Req) begin
               w_nextState = w_m0Req ? GRANT0 : IDLE;
            end else if (w_limitHit && w_m0Req) begin
               w_nextState = GRANT0;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge interface_clock or posedge reset) begin
      if (reset) begin
         r_beatCount <= '0;
      end else if (w_nextState != r_state) begin
         r_beatCount <= '0;
      end else if ((r_state != IDLE) && interface_acknowledge && (r_beatCount != BEAT_MAX)) begin
         r_beatCount <= r_beatCount + 1'b1;
      end
   end

   // A fresh error wins over a simultaneous clear request.
   always_ff @(posedge interface_clock or posedge reset) begin
      if (reset) begin
         r_protocolError <= 1'b0;
      end else if (w_errSet) begin
         r_protocolError <= 1'b1;
      end else if (protocol_error_reset) begin
         r_protocolError <= 1'b0;
      end
   end

   always_comb begin
      interface_address     = '0;
      interface_byte_enable = '0;
      interface_read        = 1'b0;
      interface_write       = 1'b0;
      interface_write_data  = '0;
      m0_acknowledge        = 1'b0;
      m1_acknowledge        = 1'b0;
      case (r_state)
         GRANT0: begin
            interface_address     = m0_address;
            interface_byte_enable = m0_byte_enable;
            interface_read        = m0_read;
            interface_write       = m0_write & ~m0_read;
            interface_write_data  = m0_write_data;
            m0_acknowledge        = interface_acknowledge;
         end
         GRANT1: begin
            interface_address     = m1_address;
            interface_byte_enable = m1_byte_enable;
            interface_read        = m1_read;
            interface_write       = m1_write & ~m1_read;
            interface_write_data  = m1_write_data;
            m1_acknowledge        = interface_acknowledge;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_avalon_arbiter.sv
// Directed bench for avalon_arbiter with a behavioural ownership model
// checked every cycle plus hand-computed expectations per scenario.
module tb_avalon_arbiter;

   localparam int WB        = 128;
   localparam int AB        = 26;
   localparam int MAX_BEATS = 4;

   logic            interface_clock = 1'b0;
   logic            reset;
   logic [AB-1:0]   m0_address, m1_address;
   logic [WB/8-1:0] m0_byte_enable, m1_byte_enable;
   logic            m0_read, m0_write, m1_read, m1_write;
   logic [WB-1:0]   m0_write_data, m1_write_data;
   logic [WB-1:0]   m0_read_data, m1_read_data;
   logic            m0_acknowledge, m1_acknowledge;
   logic [AB-1:0]   interface_address;
   logic [WB/8-1:0] interface_byte_enable;
   logic            interface_read, interface_write;
   logic [WB-1:0]   interface_write_data, interface_read_data;
   logic            interface_acknowledge;
   logic            protocol_error, protocol_error_reset;

   int checksTotal  = 0;
   int checksPassed = 0;

   avalon_arbiter #(
      .INTERFACE_WIDTH_BITS(WB),
      .INTERFACE_ADDR_BITS (AB),
      .MAX_GRANT_BEATS     (MAX_BEATS)
   ) dut (
      .interface_clock      (interface_clock),
      .reset                (reset),
      .m0_address           (m0_address),
      .m0_byte_enable       (m0_byte_enable),
      .m0_read              (m0_read),
      .m0_write             (m0_write),
      .m0_write_data        (m0_write_data),
      .m0_read_data         (m0_read_data),
      .m0_acknowledge       (m0_acknowledge),
      .m1_address           (m1_address),
      .m1_byte_enable       (m1_byte_enable),
      .m1_read              (m1_read),
      .m1_write             (m1_write),
      .m1_write_data        (m1_write_data),
      .m1_read_data         (m1_read_data),
      .m1_acknowledge       (m1_acknowledge),
      .interface_address    (interface_address),
      .interface_byte_enable(interface_byte_enable),
      .interface_read       (interface_read),
      .interface_write      (interface_write),
      .interface_write_data (interface_write_data),
      .interface_read_data  (interface_read_data),
      .interface_acknowledge(interface_acknowledge),
      .protocol_error       (protocol_error),
      .protocol_error_reset (protocol_error_reset)
   );

   always #5 interface_clock = ~interface_clock;

   task automatic checkOutput(input string name, input logic [WB-1:0] actual,
                              input logic [WB-1:0] expected);
      checksTotal++;
      if (actual === expected) begin
         checksPassed++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit rd0, input bit wr0, input bit rd1,
                                input bit wr1, input bit ack);
      m0_read = rd0;
      m0_write = wr0;
      m1_read = rd1;
      m1_write = wr1;
      interface_acknowledge = ack;
   endtask

   task automatic nextCycle();
      @(posedge interface_clock);
      #1;
   endtask

   // Ownership model: who holds the bus (-1 none), acknowledged beats in the
   // current grant, and the sticky error flag, advanced from the rules.
   int mOwner = -1;
   int mBeats = 0;
   bit mErr   = 1'b0;
   bit mReq0, mReq1, mOwnReq, mOtherReq;
   int mNext, mBeatsAfter;

   always @(posedge interface_clock or posedge reset) begin
      if (reset) begin
         mOwner = -1;
         mBeats = 0;
         mErr   = 1'b0;
      end else begin
         mReq0 = m0_read || m0_write;
         mReq1 = m1_read || m1_write;
         mNext = mOwner;
         if (mOwner < 0) begin
            mNext  = mReq0 ? 0 : (mReq1 ? 1 : -1);
            mBeats = 0;
         end else begin
            mOwnReq     = (mOwner == 0) ? mReq0 : mReq1;
            mOtherReq   = (mOwner == 0) ? mReq1 : mReq0;
            mBeatsAfter = mBeats + (interface_acknowledge ? 1 : 0);
            if (mBeatsAfter > MAX_BEATS) mBeatsAfter = MAX_BEATS;
            if (!mOwnReq) begin
               mNext = mOtherReq ? 1 - mOwner : -1;
            end else if (interface_acknowledge && mBeatsAfter == MAX_BEATS && mOtherReq) begin
               mNext = 1 - mOwner;
            end
            mBeats = (mNext != mOwner) ? 0 : mBeatsAfter;
         end
         if ((m0_read && m0_write) || (m1_read && m1_write) ||
             (mOwner < 0 && interface_acknowledge)) begin
            mErr = 1'b1;
         end else if (protocol_error_reset) begin
            mErr = 1'b0;
         end
         mOwner = mNext;
      end
   end

   // Every cycle, mid-period, compare all outputs against the model.
   always @(negedge interface_clock) begin
      logic [AB-1:0]   eAddr;
      logic [WB/8-1:0] eBe;
      logic [WB-1:0]   eWd;
      logic            eRd, eWr, eAck0, eAck1;
      eAddr = '0; eBe = '0; eWd = '0; eRd = 1'b0; eWr = 1'b0; eAck0 = 1'b0; eAck1 = 1'b0;
      if (!reset && mOwner == 0) begin
         eAddr = m0_address; eBe = m0_byte_enable; eWd = m0_write_data;
         eRd = m0_read; eWr = m0_write && !m0_read; eAck0 = interface_acknowledge;
      end else if (!reset && mOwner == 1) begin
         eAddr = m1_address; eBe = m1_byte_enable; eWd = m1_write_data;
         eRd = m1_read; eWr = m1_write && !m1_read; eAck1 = interface_acknowledge;
      end
      checkOutput("acks", {m0_acknowledge, m1_acknowledge}, {eAck0, eAck1});
      checkOutput("strobes", {interface_read, interface_write}, {eRd, eWr});
      checkOutput("address", interface_address, eAddr);
      checkOutput("byteEnable", interface_byte_enable, eBe);
      checkOutput("writeData", interface_write_data, eWd);
      checkOutput("readData0", m0_read_data, interface_read_data);
      checkOutput("readData1", m1_read_data, interface_read_data);
      checkOutput("protocolError", protocol_error, reset ? 1'b0 : mErr);
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100000");
      $fatal(1, "[TB] watchdog expired");
   end

   int m1Acks, m0Acks, grantChanges;

   initial begin
      reset = 1'b1;
      protocol_error_reset = 1'b0;
      m0_address = 26'h0001000;
      m1_address = 26'h0002000;
      m0_byte_enable = 16'hFFFF;
      m1_byte_enable = 16'h0F0F;
      m0_write_data = 128'h0;
      m1_write_data = 128'hCAFE_0000_1111_2222_3333_4444_5555_6666;
      interface_read_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      nextCycle();
      @(negedge interface_clock);
      checkOutput("resetStrobes", {interface_read, interface_write}, 2'b00);
      checkOutput("resetError", protocol_error, 1'b0);
      nextCycle();
      reset = 1'b0;

      // Simultaneous requests from IDLE: m0 wins, bus asserted next cycle.
      applyStimulus(1, 0, 0, 1, 0);
      nextCycle();
      applyStimulus(1, 0, 0, 1, 1);
      @(negedge interface_clock);
      checkOutput("bothReqM0Ack", m0_acknowledge, 1'b1);
      checkOutput("bothReqM1Ack", m1_acknowledge, 1'b0);
      checkOutput("bothReqAddr", interface_address, 26'h0001000);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();

      // m1 streaming; m0 waits exactly MAX_BEATS acknowledged m1 beats.
      applyStimulus(0, 0, 0, 1, 0);
      nextCycle();
      applyStimulus(1, 0, 0, 1, 1);
      m1Acks = 0;
      for (int i = 0; i < MAX_BEATS; i++) begin
         @(negedge interface_clock);
         if (m1_acknowledge) m1Acks++;
         nextCycle();
      end
      @(negedge interface_clock);
      checkOutput("beatLimitM1Acks", m1Acks, 4);
      checkOutput("beatLimitM0Ack", m0_acknowledge, 1'b1);
      checkOutput("beatLimitM1Ack", m1_acknowledge, 1'b0);
      checkOutput("beatLimitStrobes", {interface_read, interface_write}, 2'b10);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();

      // m0 reads 64 beats alone with incrementing address.
      m0_address = 26'h0100000;
      applyStimulus(1, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 1);
      m0Acks = 0;
      grantChanges = 0;
      for (int i = 0; i < 64; i++) begin
         m0_address = 26'h0100000 + 26'(16 * i);
         @(negedge interface_clock);
         if (m0_acknowledge) m0Acks++;
         if (m1_acknowledge || !interface_read) grantChanges++;
         checkOutput("burstAddr", interface_address, 26'h0100000 + 26'(16 * i));
         nextCycle();
      end
      checkOutput("burstM0Acks", m0Acks, 64);
      checkOutput("burstGrantChanges", grantChanges, 0);
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      applyStimulus(1, 0, 0, 0, 0);
      #1;
      checkOutput("idleAfterDrop", interface_read, 1'b0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();

      // Reset landing while m1 has a write on the bus.
      applyStimulus(0, 0, 0, 1, 0);
      nextCycle();
      @(negedge interface_clock);
      checkOutput("writeBeforeReset", interface_write, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("writeDuringReset", interface_write, 1'b0);
      nextCycle();
      reset = 1'b0;
      #1;
      checkOutput("idleAfterReset", interface_write, 1'b0);
      nextCycle();
      checkOutput("regrantAfterReset", interface_write, 1'b1);
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();

      // m1 raises read and write together.
      applyStimulus(0, 0, 1, 1, 0);
      nextCycle();
      @(negedge interface_clock);
      checkOutput("conflictStrobes", {interface_read, interface_write}, 2'b10);
      checkOutput("conflictError", protocol_error, 1'b1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
      nextCycle();
      checkOutput("errorSticky", protocol_error, 1'b1);
      protocol_error_reset = 1'b1;
      nextCycle();
      protocol_error_reset = 1'b0;
      checkOutput("errorCleared", protocol_error, 1'b0);

      // Error set coinciding with clear: set wins.
      protocol_error_reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 1);
      nextCycle();
      protocol_error_reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("errorSetWins", protocol_error, 1'b1);
      protocol_error_reset = 1'b1;
      nextCycle();
      protocol_error_reset = 1'b0;

      // Stray acknowledge in IDLE.
      applyStimulus(0, 0, 0, 0, 1);
      @(negedge interface_clock);
      checkOutput("idleAckRouted", {m0_acknowledge, m1_acknowledge}, 2'b00);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("idleAckError", protocol_error, 1'b1);
      nextCycle();
      @(negedge interface_clock);
      #1;

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule

// File: doc/avalon_arbiter.md
AVALON_ARBITER -- requirements
Module: avalon_arbiter

Interface
REQ-001 Parameters SHALL be:
- INTERFACE_WIDTH_BITS, default 128, data width.
- INTERFACE_ADDR_BITS, default 26, byte-address width.
- MAX_GRANT_BEATS, default 64, maximum consecutive acknowledged transfers per grant while the other port waits.
REQ-002 Clocking SHALL be one clock, interface_clock; reset is asynchronous and active-high, port reset.
REQ-003 Ports SHALL be as listed below; "Nx" denotes two ports, one with prefix m0_ and one with prefix m1_.
- interface_clock  in  1  sole clock.
- reset  in  1  async active-high reset.
- mN_address  in  INTERFACE_ADDR_BITS (x2)  requester byte address.
- mN_byte_enable  in  INTERFACE_WIDTH_BITS/8 (x2)  requester byte enables.
- mN_read, mN_write  in  1 each (x2)  requester strobes, held until acknowledged.
- mN_write_data  in  INTERFACE_WIDTH_BITS (x2)  requester write data.
- mN_read_data  out  INTERFACE_WIDTH_BITS (x2)  copy of interface_read_data.
- mN_acknowledge  out  1 (x2)  transfer complete for that requester.
- interface_address, interface_byte_enable, interface_read, interface_write, interface_write_data  out  bus master signals.
- interface_read_data  in  INTERFACE_WIDTH_BITS  bus read data.
- interface_acknowledge  in  1  bus transfer complete.
- protocol_error  out  1  sticky error flag.
- protocol_error_reset  in  1  synchronous clear of protocol_error.
REQ-004 Port m0 SHALL be the display line-buffer reader (high priority); port m1 SHALL be the fractal pixel writer.

Function
REQ-005 A port SHALL be requesting when its read or write strobe is high.
REQ-006 The state machine SHALL have the states IDLE, GRANT0 and GRANT1, held in a registered state; all bus outputs SHALL be combinational muxes of the granted port's inputs.
REQ-007 In IDLE, all interface outputs and both acknowledges SHALL be 0.
REQ-008 Transitions from IDLE:
- If m0 is requesting, the next state SHALL be GRANT0 (m0 wins simultaneous requests).
- Else if m1 is requesting, the next state SHALL be GRANT1.
- Grant latency SHALL be exactly 1 cycle from request to bus assertion.
REQ-009 In GRANTn, interface_acknowledge SHALL route only to mN_acknowledge; the other port's acknowledge SHALL be 0.
REQ-010 mN_read_data SHALL equal interface_read_data at all times.
REQ-011 Grant changes SHALL occur only on a cycle where interface_acknowledge=1 or the granted port is not requesting; a pending bus transfer SHALL never be re-pointed.
REQ-012 A beat counter SHALL clear on every state change and increment on each acknowledge in GRANTn, saturating at MAX_GRANT_BEATS.
REQ-013 Leaving GRANTn SHALL follow these rules:
- On the acknowledge that brings the count to MAX_GRANT_BEATS while the other port is requesting, the next state SHALL be GRANT(other).
- If the granted port is not requesting, the next state SHALL be GRANT(other) when the other port is requesting, else IDLE.
- Otherwise the state SHALL stay GRANTn.
REQ-014 m0 SHALL NOT preempt m1 before m1's beat limit or release; this bounds m0's wait to MAX_GRANT_BEATS transfers.
REQ-015 When a port asserts read and write together:
- protocol_error SHALL be set on the next edge.
- The transfer SHALL proceed as a read (write forced to 0 on the bus).
REQ-016 protocol_error SHALL hold until a cycle with protocol_error_reset=1; if protocol_error_reset and a new error coincide, the set SHALL win.
REQ-017 An acknowledge arriving in IDLE SHALL be ignored and SHALL set protocol_error.

Reset
REQ-018 Asserting reset SHALL immediately force IDLE, beat count 0 and protocol_error 0, so that all interface strobes and acknowledges read 0 during reset, including when reset lands mid-transfer.
REQ-019 After reset deasserts, arbitration SHALL resume on the first clock edge per REQ-008.

Structure
REQ-020 A shared package SHALL hold the arb_state_t enum (IDLE, GRANT0, GRANT1) and the default widths (INTERFACE_WIDTH_BITS=128, INTERFACE_ADDR_BITS=26).
REQ-021 No sub-module SHALL be instantiated; the mux and the state machine SHALL be a single module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- m0 and m1 both request in IDLE -> GRANT0 on the next cycle; m1_acknowledge stays 0.
- m1 is mid-stream and m0 requests, with MAX_GRANT_BEATS=4 -> m1 gets exactly 4 acknowledges, then m0 is granted on the following cycle.
- m0 reads 64 beats alone, with address incrementing by 16 -> 64 m0 acknowledges, no grant change, then IDLE one cycle after m0 drops read.
- Reset asserted while GRANT1 has interface_write=1 -> interface_write=0 in the same cycle; state is IDLE after release.
- m1 asserts read and write together -> interface_write=0, protocol_error=1 next cycle and sticky until protocol_error_reset.
- interface_acknowledge pulsed in IDLE -> no mN_acknowledge; protocol_error=1.
